// File: rtl/seq_detector_param_pkg.sv
// Shared types and constants for the parametrised sequence detector.
// Holds symbol encodings, the legacy pattern and the fill-width helper.
package seq_det_pkg;

  typedef enum logic [1:0] {
    SYM_NONE = 2'b00,
    SYM_X1   = 2'b01,
    SYM_X2   = 2'b10
  } sym_e;

  localparam logic [5:0] PAT_X1_X2_X2 = 6'b01_10_10;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL
  } fill_state_e;

  // fill must represent 0..LEN inclusive
  function automatic int fill_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Symbol stream, configuration and status bundle for seq_detector_param.
// master drives symbols/config, slave is the detector.
interface seq_detector_param_if
  import seq_det_pkg::*;
#(
  parameter int SYM_W = 2,
  parameter int LEN   = 3,
  parameter int CNT_W = 8
);
  localparam int FILL_W = fill_width(LEN);

  logic                   clr;
  logic                   sym_valid;
  logic [SYM_W-1:0]       sym;
  logic [LEN*SYM_W-1:0]   pattern;
  logic                   overlap;
  logic                   z;
  logic [FILL_W-1:0]      fill;
  logic [CNT_W-1:0]       match_cnt;

  modport master (
    output clr, sym_valid, sym, pattern, overlap,
    input  z, fill, match_cnt
  );

  modport slave (
    input  clr, sym_valid, sym, pattern, overlap,
    output z, fill, match_cnt
  );
endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with async active-low reset and sync clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         cp,
  input  logic         rd,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] r_q;

  always_ff @(posedge cp or negedge rd) begin
    if (!rd) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;
endmodule

// File: rtl/seq_detector_param.sv
// Programmable-pattern sequence detector: shifts in symbols, pulses z one
// cycle after the last LEN symbols equal pattern, and counts matches.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int SYM_W = 2,
  parameter int LEN   = 3,
  parameter int CNT_W = 8
) (
  input  logic                 cp,
  input  logic                 rd,
  seq_detector_param_if.slave  bus
);
  localparam int FILL_W = fill_width(LEN);
  localparam int HIST_W = LEN * SYM_W;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

  fill_state_e         r_state;
  logic [HIST_W-1:0]   r_hist;
  logic [FILL_W-1:0]   r_fill;
  logic                r_z;

  logic [HIST_W-1:0]   w_hist_n;
  logic [FILL_W-1:0]   w_fill_n;
  logic                w_full_n;
  logic                w_match;
  logic [CNT_W-1:0]    w_cnt;

  // Match is judged on the post-shift history, so the completing symbol counts.
  always_comb begin
    w_hist_n = {r_hist[HIST_W-SYM_W-1:0], bus.sym};
    w_fill_n = (r_state == ST_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
    w_full_n = (w_fill_n == FILL_FULL);
    w_match  = bus.sym_valid && w_full_n && (w_hist_n == bus.pattern);
  end

  always_ff @(posedge cp or negedge rd) begin
    if (!rd) begin
      r_state <= ST_EMPTY;
      r_hist  <= '0;
      r_fill  <= '0;
      r_z     <= 1'b0;
    end else if (bus.clr) begin
      r_state <= ST_EMPTY;
      r_fill  <= '0;
      r_z     <= 1'b0;
    end else if (bus.sym_valid) begin
      r_hist <= w_hist_n;
      r_z    <= w_match;
      if (w_match && !bus.overlap) begin
        r_state <= ST_EMPTY;
        r_fill  <= '0;
      end else begin
        r_state <= w_full_n ? ST_FULL : ST_FILLING;
        r_fill  <= w_fill_n;
      end
    end else begin
      r_z <= 1'b0;
    end
  end

  // clr outranks inc inside the counter, matching the history clear above.
  sat_counter #(.W(CNT_W)) u_cnt (
    .cp  (cp),
    .rd  (rd),
    .clr (bus.clr),
    .inc (w_match),
    .q   (w_cnt)
  );

  assign bus.z         = r_z;
  assign bus.fill      = r_fill;
  assign bus.match_cnt = w_cnt;
endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios plus a
// randomized run against a symbol-queue reference model.
module tb_seq_detector_param;
  import seq_det_pkg::*;

  localparam int SYM_W = 2;
  localparam int LEN   = 3;
  localparam int CNT_W = 8;
  localparam int SAT_W = 2;
  localparam int FW    = fill_width(LEN);
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam int MAXS  = (1 << SAT_W) - 1;

  logic cp = 1'b0;
  logic rd = 1'b0;
  always #5 cp = ~cp;

  seq_detector_param_if #(.SYM_W(SYM_W), .LEN(LEN), .CNT_W(CNT_W)) mif ();
  seq_detector_param_if #(.SYM_W(SYM_W), .LEN(LEN), .CNT_W(SAT_W)) sif ();

  assign sif.clr       = mif.clr;
  assign sif.sym_valid = mif.sym_valid;
  assign sif.sym       = mif.sym;
  assign sif.pattern   = mif.pattern;
  assign sif.overlap   = mif.overlap;

  seq_detector_param #(.SYM_W(SYM_W), .LEN(LEN), .CNT_W(CNT_W)) dut (
    .cp (cp), .rd (rd), .bus (mif)
  );
  seq_detector_param #(.SYM_W(SYM_W), .LEN(LEN), .CNT_W(SAT_W)) dut_sat (
    .cp (cp), .rd (rd), .bus (sif)
  );

  // Reference model: list of symbols seen since the last restart.
  logic [SYM_W-1:0] m_q[$];
  int   m_cnt, m_cnt_sat;
  logic m_z;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic model_hit();
    logic [LEN*SYM_W-1:0] pat;
    pat = mif.pattern;
    if (m_q.size() != LEN) return 1'b0;
    for (int i = 0; i < LEN; i++)
      if (m_q[i] != pat[(LEN-1-i)*SYM_W +: SYM_W]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cnt = 0;
    m_cnt_sat = 0;
    m_z = 1'b0;
  endtask

  task automatic cyc(input logic v, input logic [SYM_W-1:0] s, input logic c);
    mif.sym_valid = v;
    mif.sym       = s;
    mif.clr       = c;
    @(posedge cp);
    if (c) begin
      model_reset();
    end else if (v) begin
      m_q.push_back(s);
      if (m_q.size() > LEN) void'(m_q.pop_front());
      m_z = model_hit();
      if (m_z) begin
        if (m_cnt < MAXC) m_cnt++;
        if (m_cnt_sat < MAXS) m_cnt_sat++;
        if (!mif.overlap) m_q.delete();
      end
    end else begin
      m_z = 1'b0;
    end
    #1;
    mif.sym_valid = 1'b0;
    mif.clr       = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (mif.z !== 1'b0) begin n_err++; $display("FAIL reset_z: got %0b expected 0", mif.z); end
    n_cmp++; if (mif.fill !== FW'(0)) begin n_err++; $display("FAIL reset_fill: got %0d expected 0", mif.fill); end
    n_cmp++; if (mif.match_cnt !== CNT_W'(0)) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", mif.match_cnt); end
    @(negedge cp);
    rd = 1'b1;
    model_reset();
  endtask

  task automatic test_legacy();
    mif.pattern = PAT_X1_X2_X2;
    mif.overlap = 1'b0;
    cyc(1'b0, SYM_NONE, 1'b1);
    cyc(1'b1, SYM_X1, 1'b0);
    n_cmp++; if (mif.fill !== FW'(1)) begin n_err++; $display("FAIL legacy_fill1: got %0d expected 1", mif.fill); end
    cyc(1'b1, SYM_X2, 1'b0);
    n_cmp++; if (mif.z !== 1'b0) begin n_err++; $display("FAIL legacy_early_z: got %0b expected 0", mif.z); end
    cyc(1'b1, SYM_X2, 1'b0);
    n_cmp++; if (mif.z !== 1'b1) begin n_err++; $display("FAIL legacy_z: got %0b expected 1", mif.z); end
    n_cmp++; if (mif.match_cnt !== CNT_W'(1)) begin n_err++; $display("FAIL legacy_cnt: got %0d expected 1", mif.match_cnt); end
    n_cmp++; if (mif.fill !== FW'(0)) begin n_err++; $display("FAIL legacy_fill0: got %0d expected 0", mif.fill); end
    cyc(1'b0, SYM_NONE, 1'b0);
    n_cmp++; if (mif.z !== 1'b0) begin n_err++; $display("FAIL legacy_z_drop: got %0b expected 0", mif.z); end
  endtask

  task automatic test_overlap();
    mif.pattern = 6'b01_01_01;
    mif.overlap = 1'b1;
    cyc(1'b0, SYM_NONE, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, SYM_X1, 1'b0);
      n_cmp++; if (mif.z !== (i >= 2)) begin n_err++; $display("FAIL ovl_z[%0d]: got %0b expected %0b", i, mif.z, (i >= 2)); end
    end
    n_cmp++; if (mif.match_cnt !== CNT_W'(3)) begin n_err++; $display("FAIL ovl_cnt: got %0d expected 3", mif.match_cnt); end
    mif.overlap = 1'b0;
    cyc(1'b0, SYM_NONE, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, SYM_X1, 1'b0);
      n_cmp++; if (mif.z !== (i == 2)) begin n_err++; $display("FAIL novl_z[%0d]: got %0b expected %0b", i, mif.z, (i == 2)); end
    end
    n_cmp++; if (mif.match_cnt !== CNT_W'(1)) begin n_err++; $display("FAIL novl_cnt: got %0d expected 1", mif.match_cnt); end
    n_cmp++; if (mif.fill !== FW'(2)) begin n_err++; $display("FAIL novl_fill: got %0d expected 2", mif.fill); end
  endtask

  task automatic test_gaps();
    mif.pattern = PAT_X1_X2_X2;
    mif.overlap = 1'b0;
    cyc(1'b0, SYM_NONE, 1'b1);
    cyc(1'b1, SYM_X1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, SYM_X2, 1'b0);
      n_cmp++; if (mif.fill !== FW'(1) || mif.z !== 1'b0) begin n_err++; $display("FAIL gap_hold[%0d]: got fill %0d z %0b expected fill 1 z 0", i, mif.fill, mif.z); end
    end
    cyc(1'b1, SYM_X2, 1'b0);
    cyc(1'b0, SYM_X1, 1'b0);
    n_cmp++; if (mif.fill !== FW'(2) || mif.z !== 1'b0) begin n_err++; $display("FAIL gap_mid: got fill %0d z %0b expected fill 2 z 0", mif.fill, mif.z); end
    cyc(1'b1, SYM_X2, 1'b0);
    n_cmp++; if (mif.z !== 1'b1 || mif.match_cnt !== CNT_W'(1)) begin n_err++; $display("FAIL gap_match: got z %0b cnt %0d expected z 1 cnt 1", mif.z, mif.match_cnt); end
  endtask

  task automatic test_mismatch();
    logic [SYM_W-1:0] seq [5];
    seq = '{SYM_X1, SYM_X2, SYM_X1, SYM_X2, SYM_X2};
    mif.pattern = PAT_X1_X2_X2;
    mif.overlap = 1'b1;
    cyc(1'b0, SYM_NONE, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, seq[i], 1'b0);
      n_cmp++; if (mif.z !== (i == 4)) begin n_err++; $display("FAIL mm_z[%0d]: got %0b expected %0b", i, mif.z, (i == 4)); end
      if (i >= 2) begin
        n_cmp++; if (mif.fill !== FW'(3)) begin n_err++; $display("FAIL mm_fill[%0d]: got %0d expected 3", i, mif.fill); end
      end
    end
    n_cmp++; if (mif.match_cnt !== CNT_W'(1)) begin n_err++; $display("FAIL mm_cnt: got %0d expected 1", mif.match_cnt); end
  endtask

  task automatic test_saturation();
    mif.pattern = 6'b01_01_01;
    mif.overlap = 1'b1;
    cyc(1'b0, SYM_NONE, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, SYM_X1, 1'b0);
      if (i >= 4) begin
        n_cmp++; if (sif.match_cnt !== SAT_W'(3)) begin n_err++; $display("FAIL sat_cnt[%0d]: got %0d expected 3", i, sif.match_cnt); end
      end
    end
    n_cmp++; if (mif.match_cnt !== CNT_W'(6)) begin n_err++; $display("FAIL sat_wide_cnt: got %0d expected 6", mif.match_cnt); end
  endtask

  task automatic test_async_reset_clr();
    mif.pattern = PAT_X1_X2_X2;
    mif.overlap = 1'b0;
    cyc(1'b1, SYM_X1, 1'b0);
    cyc(1'b1, SYM_X2, 1'b0);
    #2 rd = 1'b0;
    #1;
    n_cmp++; if (mif.fill !== FW'(0)) begin n_err++; $display("FAIL arst_fill: got %0d expected 0", mif.fill); end
    n_cmp++; if (mif.match_cnt !== CNT_W'(0)) begin n_err++; $display("FAIL arst_cnt: got %0d expected 0", mif.match_cnt); end
    model_reset();
    #1 rd = 1'b1;
    cyc(1'b1, SYM_X1, 1'b0);
    cyc(1'b1, SYM_X2, 1'b0);
    cyc(1'b1, SYM_X2, 1'b1);
    n_cmp++; if (mif.z !== 1'b0 || mif.match_cnt !== CNT_W'(0) || mif.fill !== FW'(0)) begin
      n_err++; $display("FAIL clr_prio: got z %0b cnt %0d fill %0d expected 0 0 0", mif.z, mif.match_cnt, mif.fill);
    end
  endtask

  task automatic test_random();
    logic [LEN*SYM_W-1:0] p;
    logic [SYM_W-1:0]     s;
    logic                 v, c;
    for (int n = 0; n < 600; n++) begin
      c = 1'b0;
      if (n % 60 == 0) begin
        p = '0;
        for (int k = 0; k < LEN; k++) p = {p[(LEN-1)*SYM_W-1:0], ($urandom_range(0, 1) != 0) ? SYM_X1 : SYM_X2};
        mif.pattern = p;
        c = 1'b1;
      end else if ($urandom_range(0, 49) == 0) begin
        c = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) mif.overlap = ($urandom_range(0, 1) != 0);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) == 0) ? SYM_NONE : (($urandom_range(0, 1) != 0) ? SYM_X1 : SYM_X2);
      cyc(v, s, c);
      n_cmp++; if (mif.z !== m_z) begin n_err++; $display("FAIL rnd_z[%0d]: got %0b expected %0b", n, mif.z, m_z); end
      n_cmp++; if (mif.fill !== FW'(m_q.size())) begin n_err++; $display("FAIL rnd_fill[%0d]: got %0d expected %0d", n, mif.fill, m_q.size()); end
      n_cmp++; if (mif.match_cnt !== CNT_W'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", n, mif.match_cnt, m_cnt); end
      n_cmp++; if (sif.match_cnt !== SAT_W'(m_cnt_sat)) begin n_err++; $display("FAIL rnd_sat_cnt[%0d]: got %0d expected %0d", n, sif.match_cnt, m_cnt_sat); end
    end
  endtask

  initial begin
    mif.sym_valid = 1'b0;
    mif.sym       = SYM_NONE;
    mif.clr       = 1'b0;
    mif.pattern   = PAT_X1_X2_X2;
    mif.overlap   = 1'b0;
    model_reset();
    test_reset();
    test_legacy();
    test_overlap();
    test_gaps();
    test_mismatch();
    test_saturation();
    test_async_reset_clr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised synchronous sequence detector: accepts one SYM_W-bit symbol per qualified clock and raises a one-cycle `z` pulse when the last LEN symbols equal a programmable pattern. Supports overlapping and non-overlapping detection, and keeps a saturating match count. It succeeds the fixed x1‑x2‑x2 pulse-mode detector. Legacy behaviour is reproduced with the default parameters and `pattern = 6'b01_10_10`. It sits between the debounced switch/button front end and the LED output stage.

## Interface
- SYM_W, 2, symbol width in bits.
- LEN, 3, sequence length in symbols (≥2).
- CNT_W, 8, match counter width.
- cp  input  1  clock. All state updates on posedge.
- rd  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous clear of history fill, count and `z`.
- sym_valid  input  1  the `sym` input is sampled this cycle.
- sym  input  SYM_W  incoming symbol.
- pattern  input  LEN*SYM_W  target sequence. The MSB slice is the first symbol. Must be held stable while `sym_valid` may assert.
- overlap  input  1  1 = overlapping detection, 0 = history restarts after each match.
- z  output  1  one-cycle match pulse.
- fill  output  $clog2(LEN+1)  number of valid symbols in history (0..LEN).
- match_cnt  output  CNT_W  saturating number of matches since reset/clr.

## Operation
- History register `hist` holds LEN*SYM_W bits.
  - On `sym_valid`: hist_n = {hist[(LEN-1)*SYM_W-1:0], sym}. The newest symbol goes to the LSB slice.
  - fill_n = min(fill+1, LEN).
- Match condition, evaluated on the next values: `sym_valid && fill_n == LEN && hist_n == pattern`.
- On match:
  - `z` = 1 on the following cycle.
  - `match_cnt` increments. It saturates at 2^CNT_W−1 and does not wrap.
  - If `overlap` = 0, `fill` becomes 0 instead of LEN. `hist` still shifts, but its contents are don't-care.
  - If `overlap` = 1, `fill` stays at LEN.
- Without `sym_valid`: `hist`, `fill` and `match_cnt` hold, and `z` = 0.
- Priority: `rd` low > `clr` > `sym_valid`.
  - `clr` sets `fill` = 0, `match_cnt` = 0 and `z` = 0, ignoring any simultaneous symbol.
- Fill state machine: EMPTY (fill=0) → FILLING (0<fill<LEN) → FULL (fill=LEN).
  - FULL → EMPTY happens only on a non-overlap match or `clr`.
  - Overlap-mode matches keep the machine in FULL.
- Reset values: `z` = 0, `fill` = 0, `match_cnt` = 0, `hist` = 0.
- Reset asserted mid-sequence discards partial history immediately, asynchronously.

## Timing
- `z` is registered. It is high during the cycle after the posedge that sampled the final matching symbol.
- `match_cnt` updates on the same edge that sets `z`.
- `fill` updates on the sampling edge.
- Back-to-back matches in overlap mode can occur on consecutive valid symbols only if the pattern is periodic. `z` then stays high on consecutive cycles, one pulse per match.
- Changing `overlap` takes effect from the next sampled symbol.
- Changing `pattern` mid-sequence has an undefined result for the current match only.
- No combinational path from inputs to outputs.

## Structure
- Package `seq_det_pkg` holds:
  - symbol encodings: SYM_NONE = 2'b00, SYM_X1 = 2'b01, SYM_X2 = 2'b10;
  - legacy pattern constant PAT_X1_X2_X2 = 6'b011010;
  - the function computing the `fill` width.
- Sub-module `sat_counter` (parameter W; inputs cp, rd, clr, inc; output q) implements `match_cnt`.
- All other logic stays in the top module.

## Test plan
- Legacy default, `overlap` = 0, symbols 01,10,10 → `z` pulses once on the cycle after the third symbol; `match_cnt` = 1; `fill` returns to 0.
- Overlap, pattern 01_01_01, five valid 01 symbols → `z` high for 3 consecutive cycles; `match_cnt` = 3. With `overlap` = 0 the same input gives 1 match, and `fill` = 2 at the end.
- Gaps: 01, idle 4 cycles, 10, idle, 10 → one match; `fill` holds during idle cycles; no spurious `z`.
- Mismatch: 01,10,01,10,10 → exactly one match after the 5th symbol. `fill` = 3 from the 3rd symbol onward.
- Saturation: CNT_W = 2, overlap, 6 matches → `match_cnt` sticks at 3.
- `rd` pulsed low asynchronously between posedges after two matching symbols → `fill` = 0 immediately. Then `clr` asserted together with a completing symbol → no `z`, and `match_cnt` = 0.
